// File: rtl/register_readout_unit.sv
// -----------------------------------------------------------------------------
// register_readout_unit
//
// Reader side of the register bank.
// A start request takes a snapshot of every register from the packed reg_bus.
// The unit then streams the snapshot out one word per valid/ready transfer,
// starting at index 0. After the last word is accepted it pulses done for one
// cycle and returns to idle.
//
// State table
//   state   | meaning
//   --------+---------------------------------------------------------------
//   st_idle | waiting for start; outputs quiet
//   st_send | offering snapshot[out_idx]; advances on each accepted transfer
//   st_done | one-cycle completion pulse, busy still high
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   reg_bus    packed register outputs; reg i = reg_bus[i*word_size +: word_size]
//   start      readout request, sampled only in st_idle
//   d_out      word currently offered
//   out_idx    register index of d_out
//   out_valid  d_out/out_idx valid
//   out_ready  consumer accepts the word when high together with out_valid
//   busy       high in st_send and st_done
//   done       one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module register_readout_unit #(
    parameter int word_size = 8,
    parameter int num_regs  = 4,
    parameter int idx_w     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [word_size*num_regs-1:0] reg_bus,
    input  logic                          start,
    output logic [word_size-1:0]          d_out,
    output logic [idx_w-1:0]              out_idx,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_send = 2'd1,
        st_done = 2'd2
    } state_t;

    localparam logic [idx_w-1:0] last_idx = idx_w'(num_regs - 1);

    state_t               state;
    logic [word_size-1:0] snapshot [num_regs];
    logic [idx_w-1:0]     next_idx;
    logic                 xfer;

    assign next_idx = out_idx + idx_w'(1);
    assign xfer     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= st_idle;
            d_out     <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < num_regs; i++) begin
                snapshot[i] <= '0;
            end
        end else begin
            case (state)
                st_idle: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < num_regs; i++) begin
                            snapshot[i] <= reg_bus[i*word_size +: word_size];
                        end
                        // Word 0 goes straight from the bus so it is offered
                        // in the first SEND cycle without waiting on the snapshot.
                        d_out     <= reg_bus[word_size-1:0];
                        out_idx   <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= st_send;
                    end
                end

                st_send: begin
                    if (xfer) begin
                        if (out_idx == last_idx) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= st_done;
                        end else begin
                            out_idx <= next_idx;
                            d_out   <= snapshot[next_idx];
                        end
                    end
                end

                st_done: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= st_idle;
                end

                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= st_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_readout_unit.sv
// -----------------------------------------------------------------------------
// tb_register_readout_unit
//
// Directed bench for register_readout_unit. A transaction-level model tracks the
// readout (captured words, position, completion pulse) and a negedge process
// compares the DUT against it every cycle. Literal expectations per scenario
// pin the model itself.
// -----------------------------------------------------------------------------
module tb_register_readout_unit;

    localparam int W = 8;
    localparam int N = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [W*N-1:0]  reg_bus;
    logic            start;
    logic [W-1:0]    d_out;
    logic [IW-1:0]   out_idx;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic            done;

    register_readout_unit #(.word_size(W), .num_regs(N), .idx_w(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .reg_bus   (reg_bus),
        .start     (start),
        .d_out     (d_out),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_words [N];
    int  m_pos      = 0;
    bit  m_stream   = 0;
    bit  m_done     = 0;
    bit  m_cleared  = 0;   // outputs known-zero since last reset

    always @(posedge clk) begin
        if (rst) begin
            m_stream  = 0;
            m_done    = 0;
            m_pos     = 0;
            m_cleared = 1;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_stream) begin
            if (out_ready) begin
                if (m_pos == N - 1) begin
                    m_stream = 0;
                    m_done   = 1;
                end else begin
                    m_pos++;
                end
            end
        end else if (start) begin
            for (int i = 0; i < N; i++) m_words[i] = int'((reg_bus >> (i * W)) & 32'hFF);
            m_pos     = 0;
            m_stream  = 1;
            m_cleared = 0;
        end
    end

    // ---------------- compare + monitor ----------------
    int act_w[$];
    int act_i[$];
    int gaps[$];
    int done_cnt  = 0;
    bit gap_on    = 0;
    int gap_run   = 0;
    bit cmp_en    = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_valid", int'(out_valid), int'(m_stream));
            chk("cyc_busy",  int'(busy),      int'(m_stream | m_done));
            chk("cyc_done",  int'(done),      int'(m_done));
            if (m_stream) begin
                chk("cyc_d_out", int'(d_out),   m_words[m_pos]);
                chk("cyc_idx",   int'(out_idx), m_pos);
            end else if (m_cleared) begin
                chk("cyc_d_out_rst", int'(d_out),   0);
                chk("cyc_idx_rst",   int'(out_idx), 0);
            end
        end
        if (out_valid && out_ready) begin
            act_w.push_back(int'(d_out));
            act_i.push_back(int'(out_idx));
        end
        if (done) begin
            done_cnt++;
            gap_on  = 1;
            gap_run = 0;
        end else if (gap_on) begin
            if (out_valid) begin
                gaps.push_back(gap_run);
                gap_on = 0;
            end else if (!busy) begin
                gap_run++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        act_w.delete();
        act_i.delete();
        gaps.delete();
        done_cnt = 0;
        gap_on   = 0;
        gap_run  = 0;
    endtask

    task automatic chk_stream(input string tag, input logic [W*N-1:0] bus);
        chk({tag, "_count"}, act_w.size(), N);
        for (int i = 0; i < N && i < act_w.size(); i++) begin
            chk({tag, "_word"}, act_w[i], int'((bus >> (i * W)) & 32'hFF));
            chk({tag, "_idx"},  act_i[i], i);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        reg_bus   = '0;

        // 1: reset
        tick(2);
        rst    = 1'b0;
        cmp_en = 1'b1;
        tick(1);
        chk("rst_d_out",     int'(d_out),     0);
        chk("rst_idx",       int'(out_idx),   0);
        chk("rst_valid",     int'(out_valid), 0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_done",      int'(done),      0);

        // 2: basic stream
        clear_logs();
        reg_bus   = 32'h44332211;
        out_ready = 1'b1;
        start     = 1'b1;
        tick(1);
        start = 1'b0;
        chk("s2_first_valid", int'(out_valid), 1);
        chk("s2_first_word",  int'(d_out),     32'h11);
        tick(6);
        chk_stream("s2", 32'h44332211);
        chk("s2_done_cnt", done_cnt, 1);
        chk("s2_busy_end", int'(busy), 0);

        // 3: backpressure at idx 1
        clear_logs();
        out_ready = 1'b1;
        start     = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            chk("s3_hold_word",  int'(d_out),     32'h22);
            chk("s3_hold_idx",   int'(out_idx),   1);
            chk("s3_hold_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        tick(6);
        chk_stream("s3", 32'h44332211);
        chk("s3_done_cnt", done_cnt, 1);

        // 4: snapshot isolation, start during SEND ignored
        clear_logs();
        start = 1'b1;
        tick(1);
        start   = 1'b0;
        reg_bus = '1;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(8);
        chk_stream("s4", 32'h44332211);
        chk("s4_done_cnt", done_cnt, 1);
        chk("s4_no_rerun", int'(out_valid), 0);

        // 5: reset mid-stream at idx 2, then fresh readout
        reg_bus = 32'h44332211;
        start   = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        chk("s5_pre_idx", int'(out_idx), 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("s5_rst_valid", int'(out_valid), 0);
        chk("s5_rst_d_out", int'(d_out),     0);
        chk("s5_rst_idx",   int'(out_idx),   0);
        chk("s5_rst_busy",  int'(busy),      0);
        chk("s5_rst_done",  int'(done),      0);
        clear_logs();
        reg_bus = 32'hDDCCBBAA;
        start   = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        chk_stream("s5", 32'hDDCCBBAA);

        // 6: start held high -> back-to-back readouts, one idle cycle apart
        clear_logs();
        reg_bus = 32'h44332211;
        start   = 1'b1;
        tick(18);
        start = 1'b0;
        chk("s6_done_cnt", done_cnt, 3);
        chk("s6_words",    act_w.size(), 3 * N);
        chk("s6_gap_cnt",  gaps.size(), 2);
        for (int g = 0; g < gaps.size(); g++) chk("s6_gap_len", gaps[g], 1);
        tick(8);
        chk("s6_idle_end", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
